// File: rtl/uart_rx_packer.sv
// uart_rx_packer: groups 9-bit UART characters into AXI-Stream packets.
// A packet closes when it reaches MAX_LEN bytes, when the line stays idle
// for idle_cycles clocks, or on a flush request. Storage is a single hold
// register plus the output register; the held byte is only released once
// the next byte (or the packet end) is known, so tlast is always exact.
//
// Handshake rule (both ports): a beat transfers on a rising clk edge where
// tvalid && tready are both high; the producer keeps tvalid and its payload
// stable until that edge, and the consumer may drive tready freely.
module uart_rx_packer #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] idle_cycles,
  input  logic             flush,
  input  logic [8:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             recv_timeout,
  output logic [15:0]      pkt_count,
  output logic [1:0]       o_dbg_state
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_CLOSE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [8:0]         r_hold;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_next;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_next;
  logic [7:0]         r_m_tdata;
  logic               r_m_tuser;
  logic               r_m_tvalid;
  logic               r_m_tlast;
  logic               r_recv_timeout;
  logic [15:0]        r_pkt_count;

  logic               w_out_free;
  logic               w_timeout;
  logic               w_s_ready;
  logic               w_hold_load;
  logic               w_out_load;
  logic               w_out_last;
  logic               w_to_pulse;

  assign w_out_free = !r_m_tvalid || m_axis_tready;
  // Threshold is idle_cycles-1 because the timer reads 0 in the first idle cycle.
  assign w_timeout  = (idle_cycles != '0) && (r_timer >= (idle_cycles - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, handshake and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_s_ready    = 1'b0;
    w_hold_load  = 1'b0;
    w_out_load   = 1'b0;
    w_out_last   = 1'b0;
    w_to_pulse   = 1'b0;
    w_len_next   = r_len;
    w_timer_next = r_timer;
    case (r_state)
      S_IDLE: begin
        w_s_ready = 1'b1;
        if (s_axis_tvalid) begin
          w_hold_load  = 1'b1;
          w_len_next   = LEN_W'(1);
          w_timer_next = '0;
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        w_s_ready = w_out_free;
        if (s_axis_tvalid && w_out_free) begin
          // A new byte proves the held one is not the last: push it out.
          w_out_load   = 1'b1;
          w_hold_load  = 1'b1;
          w_len_next   = r_len + LEN_W'(1);
          w_timer_next = '0;
          if (w_len_next == LEN_W'(MAX_LEN)) begin
            w_next_state = S_CLOSE;
          end
        end else begin
          w_timer_next = (r_timer == '1) ? r_timer : r_timer + CNT_W'(1);
          if (w_timeout) begin
            w_to_pulse   = 1'b1;
            w_next_state = S_CLOSE;
          end else if (flush) begin
            w_next_state = S_CLOSE;
          end
        end
      end
      S_CLOSE: begin
        if (w_out_free) begin
          w_out_load   = 1'b1;
          w_out_last   = 1'b1;
          w_len_next   = '0;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Hold register, packet length and idle timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_len   <= '0;
      r_timer <= '0;
    end else begin
      if (w_hold_load) begin
        r_hold <= s_axis_tdata;
      end
      r_len   <= w_len_next;
      r_timer <= w_timer_next;
    end
  end

  // Output register: reload from hold, or drop valid once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_out_load) begin
      r_m_tdata  <= r_hold[7:0];
      r_m_tuser  <= r_hold[8];
      r_m_tlast  <= w_out_last;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Timeout pulse and emitted-packet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_recv_timeout <= 1'b0;
      r_pkt_count    <= '0;
    end else begin
      r_recv_timeout <= w_to_pulse;
      if (r_m_tvalid && m_axis_tready && r_m_tlast) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign recv_timeout  = r_recv_timeout;
  assign pkt_count     = r_pkt_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer (MAX_LEN=4 so length-closing is exercised often).
module tb_uart_rx_packer;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] idle_cycles;
  logic             flush;
  logic [8:0]       s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             recv_timeout;
  logic [15:0]      pkt_count;
  logic [1:0]       dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_data_q[$];
  logic        obs_last_q[$];
  int          to_pulses = 0;
  int          in_count  = 0;
  int          out_count = 0;
  int          cur_len   = 0;
  logic [15:0] model_pkt = '0;
  bit          rand_run  = 1'b0;

  uart_rx_packer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .idle_cycles   (idle_cycles),
    .flush         (flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .recv_timeout  (recv_timeout),
    .pkt_count     (pkt_count),
    .o_dbg_state   (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: samples on the falling edge, i.e. the handshake about to happen.
  task automatic monitor();
    logic [8:0] e;
    logic [8:0] a;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        cur_len   = 0;
        model_pkt = '0;
      end else begin
        n_checks++;
        if (pkt_count !== model_pkt) begin
          n_fail++;
          $display("FAIL pkt_count: got %0d expected %0d", pkt_count, model_pkt);
        end
        if (recv_timeout) to_pulses++;
        if (s_axis_tvalid && s_axis_tready) begin
          exp_q.push_back(s_axis_tdata);
          in_count++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          a = {m_axis_tuser, m_axis_tdata};
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got %h with no byte outstanding", a);
          end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
              n_fail++;
              $display("FAIL out_data: got %h expected %h", a, e);
            end
          end
          obs_data_q.push_back(a);
          obs_last_q.push_back(m_axis_tlast);
          out_count++;
          cur_len++;
          n_checks++;
          if (cur_len > MAX_LEN) begin
            n_fail++;
            $display("FAIL pkt_len: got %0d bytes, limit %0d", cur_len, MAX_LEN);
          end
          if (m_axis_tlast) begin
            cur_len   = 0;
            model_pkt = model_pkt + 16'd1;
          end
        end
      end
    end
  endtask

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    flush         = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
  endtask

  task automatic clear_obs();
    obs_data_q.delete();
    obs_last_q.delete();
    to_pulses = 0;
  endtask

  task automatic send_byte(input logic [8:0] d);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 2000);
    s_axis_tvalid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted in %0d cycles", d, waited);
    end
  endtask

  function automatic logic [15:0] last_bits();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < obs_last_q.size() && i < 16; i++) v[i] = obs_last_q[i];
    return v;
  endfunction

  // Scenarios
  task automatic test_reset();
    #12;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, recv_timeout, pkt_count, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h u=%b l=%b to=%b cnt=%0d st=%0d, all zero required",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, recv_timeout, pkt_count, dbg_state);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_axis_tready !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b state=%0d expected ready=1 state=0", s_axis_tready, dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int k;
    bit found;
    do_reset();
    idle_cycles   = 10;
    m_axis_tready = 1'b1;
    clear_obs();
    send_byte(9'h041);
    send_byte(9'h042);
    send_byte(9'h043);
    k = 0;
    found = 1'b0;
    while (k < 40 && !found) begin
      @(negedge clk);
      k++;
      if (recv_timeout) found = 1'b1;
    end
    n_checks++;
    if (!found || k != 11) begin
      n_fail++;
      $display("FAIL timeout_delay: pulse seen=%b after %0d cycles expected after 11", found, k);
    end
    wait_cycles(5);
    n_checks++;
    if (obs_last_q.size() != 3 || last_bits() !== 16'h0004) begin
      n_fail++;
      $display("FAIL timeout_tlast: got %0d beats tlast=%b expected 3 beats tlast=100", obs_last_q.size(), last_bits());
    end
    n_checks++;
    if (to_pulses != 1 || pkt_count !== 16'd1) begin
      n_fail++;
      $display("FAIL timeout_count: got pulses=%0d pkts=%0d expected 1 and 1", to_pulses, pkt_count);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    idle_cycles   = '0;
    m_axis_tready = 1'b1;
    clear_obs();
    for (int i = 0; i < 9; i++) send_byte(9'(i));
    wait_cycles(10);
    n_checks++;
    if (obs_last_q.size() != 8 || last_bits() !== 16'h0088 || dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL maxlen_pkts: got %0d beats tlast=%b state=%0d expected 8 beats tlast=10001000 state=1",
               obs_last_q.size(), last_bits(), dbg_state);
    end
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    wait_cycles(5);
    n_checks++;
    if (obs_last_q.size() != 9 || last_bits() !== 16'h0188 || obs_data_q[8] !== 9'h008) begin
      n_fail++;
      $display("FAIL maxlen_flush: got %0d beats tlast=%b expected 9 beats tlast=110001000 last byte 008",
               obs_last_q.size(), last_bits());
    end
    n_checks++;
    if (pkt_count !== 16'd3 || to_pulses != 0) begin
      n_fail++;
      $display("FAIL maxlen_count: got pkts=%0d pulses=%0d expected 3 and 0", pkt_count, to_pulses);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    idle_cycles   = 5;
    m_axis_tready = 1'b1;
    clear_obs();
    send_byte(9'h011);
    send_byte(9'h112);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || {m_axis_tuser, m_axis_tdata} !== 9'h011 || m_axis_tlast !== 1'b0 ||
          s_axis_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_stable: cycle %0d got v=%b d=%h l=%b sready=%b expected v=1 d=011 l=0 sready=0",
                 i, m_axis_tvalid, {m_axis_tuser, m_axis_tdata}, m_axis_tlast, s_axis_tready);
      end
      if (i >= 5) begin
        n_checks++;
        if (dbg_state !== 2'd2) begin
          n_fail++;
          $display("FAIL stall_state: cycle %0d got state %0d expected 2", i, dbg_state);
        end
      end
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_cycles(5);
    n_checks++;
    if (obs_last_q.size() != 2 || last_bits() !== 16'h0002 || obs_data_q[1] !== 9'h112) begin
      n_fail++;
      $display("FAIL stall_release: got %0d beats tlast=%b expected 2 beats tlast=10 last byte 112",
               obs_last_q.size(), last_bits());
    end
    n_checks++;
    if (to_pulses != 1 || pkt_count !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_count: got pulses=%0d pkts=%0d expected 1 and 1", to_pulses, pkt_count);
    end
  endtask

  task automatic test_coincident();
    int k;
    bit found;
    do_reset();
    idle_cycles   = 3;
    m_axis_tready = 1'b1;
    clear_obs();
    send_byte(9'h021);
    wait_cycles(2);
    flush = 1'b1;
    send_byte(9'h022);
    flush = 1'b0;
    k = 0;
    found = 1'b0;
    while (k < 20 && !found) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        n_checks++;
        if (dbg_state !== 2'd1) begin
          n_fail++;
          $display("FAIL coincide_state: got state %0d expected 1", dbg_state);
        end
      end
      if (recv_timeout) found = 1'b1;
    end
    n_checks++;
    if (!found || k != 4) begin
      n_fail++;
      $display("FAIL coincide_restart: pulse seen=%b after %0d cycles expected after 4", found, k);
    end
    wait_cycles(4);
    n_checks++;
    if (obs_last_q.size() != 2 || last_bits() !== 16'h0002 || to_pulses != 1) begin
      n_fail++;
      $display("FAIL coincide_pkt: got %0d beats tlast=%b pulses=%0d expected 2 beats tlast=10 pulses=1",
               obs_last_q.size(), last_bits(), to_pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle_cycles   = '0;
    m_axis_tready = 1'b1;
    send_byte(9'h030);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    wait_cycles(3);
    m_axis_tready = 1'b0;
    send_byte(9'h031);
    send_byte(9'h032);
    wait_cycles(2);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || pkt_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_setup: got v=%b pkts=%0d expected v=1 pkts=1", m_axis_tvalid, pkt_count);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, recv_timeout, pkt_count, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b d=%h l=%b cnt=%0d st=%0d, all zero required",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, pkt_count, dbg_state);
    end
    wait_cycles(2);
    rst = 1'b0;
    clear_obs();
    @(negedge clk);
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b expected 1", s_axis_tready);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_cycles(20);
    n_checks++;
    if (obs_last_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_stale: got %0d beats after reset expected 0", obs_last_q.size());
    end
    send_byte(9'h133);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    wait_cycles(5);
    n_checks++;
    if (obs_last_q.size() != 1 || obs_data_q[0] !== 9'h133 || obs_last_q[0] !== 1'b1 || pkt_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_newpkt: got %0d beats pkts=%0d expected one 133 with tlast, pkts=1",
               obs_last_q.size(), pkt_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int w;
    do_reset();
    idle_cycles = 3;
    clear_obs();
    in_count  = 0;
    out_count = 0;
    rand_run  = 1'b1;
    fork
      while (rand_run) begin
        @(posedge clk);
        #1;
        m_axis_tready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 10000; i++) begin
      wait_cycles($urandom_range(0, 2));
      if ($urandom_range(0, 31) == 0) begin
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
      end
      d = 8'($urandom_range(0, 255));
      send_byte({d[0], d});
    end
    rand_run = 1'b0;
    wait_cycles(3);
    m_axis_tready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      wait_cycles(1);
      w++;
    end
    wait_cycles(2);
    n_checks++;
    if (exp_q.size() != 0 || out_count != in_count || in_count != 10000) begin
      n_fail++;
      $display("FAIL random_drain: got in=%0d out=%0d pending=%0d expected 10000 in, all out",
               in_count, out_count, exp_q.size());
    end
    n_checks++;
    if (cur_len != 0 || int'(pkt_count) < 2500) begin
      n_fail++;
      $display("FAIL random_pkts: got open_len=%0d pkts=%0d expected 0 and at least 2500", cur_len, pkt_count);
    end
  endtask

  // Sequence and final report
  initial begin
    rst           = 1'b1;
    idle_cycles   = '0;
    flush         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_timeout();
    test_max_len();
    test_backpressure();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
